// File: rtl/bcd_to_bin_if.sv
// Handshake/data bundle for the BCD-to-binary converter.
//
// Handshake: the requester raises start with bcd_in valid; the converter
// accepts it on any rising edge where busy is low (state IDLE). While busy
// is high start is ignored, and nothing is queued. valid is a single-cycle
// pulse that marks a new bin_out/err. There is no back-pressure, and
// bin_out/err hold their values until the next valid pulse.
interface bcd_to_bin_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
);
  logic                  start;
  logic [DIGITS*4-1:0]   bcd_in;
  logic                  busy;
  logic                  valid;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;

  // Requester side (keypad / front-panel entry logic).
  modport master (
    output start,
    output bcd_in,
    input  busy,
    input  valid,
    input  bin_out,
    input  err
  );

  // Converter side.
  modport slave (
    input  start,
    input  bcd_in,
    output busy,
    output valid,
    output bin_out,
    output err
  );
endinterface

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to unsigned binary converter.
// Processes one digit per clock, most-significant digit first, using
// acc = acc*10 + digit. The FSM runs IDLE -> CONV (DIGITS cycles) -> DONE -> IDLE.
// Optional build macro BCD_TO_BIN_CHECK_EN: digits above 9 set a sticky error.
// A conversion that sees such a digit then reports err=1 and an all-ones result.
// state_dbg exposes the FSM state (0=IDLE, 1=CONV, 2=DONE).
module bcd_to_bin #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  bcd_to_bin_if.slave   bus,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t              state;
  state_t              state_nxt;
  logic [DIGITS*4-1:0] shadow;
  logic [IDX_W-1:0]    idx;
  logic [BIN_W-1:0]    acc;
  logic [BIN_W-1:0]    acc_nxt;
  logic [3:0]          digit;
  logic                accept;
  logic                busy_int;
  logic                done_exit;
  logic                valid_q;
  logic [BIN_W-1:0]    bin_q;
  logic                err_q;
  logic [BIN_W-1:0]    result_bin;
  logic                result_err;

  // A request is taken only from IDLE, so an in-flight operand is never overwritten.
  assign accept = (state == S_IDLE) && bus.start;

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: CONV ends on the edge that processes digit index 0.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.start) state_nxt = S_CONV;
      S_CONV: if (idx == '0) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM output decode: busy covers CONV and DONE, and DONE's exiting edge loads the result.
  always_comb begin
    busy_int  = 1'b0;
    done_exit = 1'b0;
    case (state)
      S_CONV: busy_int = 1'b1;
      S_DONE: begin
        busy_int  = 1'b1;
        done_exit = 1'b1;
      end
      default: begin
        busy_int  = 1'b0;
        done_exit = 1'b0;
      end
    endcase
  end

  // Select the digit addressed by idx from the captured operand.
  always_comb begin
    digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) digit = shadow[i*4 +: 4];
    end
  end

  // acc*10 + digit as two shifts and adds, truncated to BIN_W bits.
  always_comb begin
    acc_nxt = (acc << 3) + (acc << 1) + BIN_W'(digit);
  end

  // Operand capture, accumulator and digit index.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      shadow <= '0;
      idx    <= '0;
      acc    <= '0;
    end else if (accept) begin
      shadow <= bus.bcd_in;
      idx    <= IDX_LAST;
      acc    <= '0;
    end else if (state == S_CONV) begin
      acc <= acc_nxt;
      if (idx != '0) idx <= idx - IDX_ONE;
    end
  end

`ifdef BCD_TO_BIN_CHECK_EN
  logic err_sticky;

  // Sticky invalid-digit flag: cleared per request and set by any digit above 9 seen in CONV.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      err_sticky <= 1'b0;
    end else if (accept) begin
      err_sticky <= 1'b0;
    end else if ((state == S_CONV) && (digit > 4'd9)) begin
      err_sticky <= 1'b1;
    end
  end

  // A flagged conversion reports all ones rather than a misleading number.
  always_comb begin
    result_err = err_sticky;
    result_bin = err_sticky ? {BIN_W{1'b1}} : acc;
  end
`else
  // No digit checking: digits 10..15 feed the arithmetic unchanged.
  always_comb begin
    result_err = 1'b0;
    result_bin = acc;
  end
`endif

  // Result registers: loaded on DONE's exiting edge, and valid pulses for one cycle.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      valid_q <= 1'b0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (done_exit) begin
        valid_q <= 1'b1;
        bin_q   <= result_bin;
        err_q   <= result_err;
      end
    end
  end

  assign bus.busy    = busy_int;
  assign bus.valid   = valid_q;
  assign bus.bin_out = bin_q;
  assign bus.err     = err_q;
  assign state_dbg   = state;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed-vector bench for bcd_to_bin at the default DIGITS=4, BIN_W=14.
module tb_bcd_to_bin;
  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;
  localparam int LAT    = DIGITS + 1;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [1:0] state_dbg;
  int         vec_cnt;
  int         miss_cnt;

  bcd_to_bin_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd_to_bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // 25 MHz clock.
  initial begin
    sys_clk = 1'b0;
    forever #20 sys_clk = ~sys_clk;
  end

  // Absolute time bound on the whole run.
  initial begin
    #2000000;
    $display("FAIL watchdog: run still active at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  // Apply one request from a negedge and wait (bounded) for its valid pulse.
  // lat is the index of the edge after start acceptance (edge 0) that raised valid, or -1.
  task automatic do_conv(input logic [15:0] bcd, output logic [BIN_W-1:0] bin,
                         output logic e, output int lat, output int busy_cyc);
    bus.start  = 1'b1;
    bus.bcd_in = bcd;
    @(posedge sys_clk);
    #1;
    bus.start  = 1'b0;
    bus.bcd_in = 16'hFFFF;
    lat      = -1;
    busy_cyc = 0;
    bin      = '0;
    e        = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge sys_clk);
      if (bus.busy) busy_cyc++;
      if (bus.valid) begin
        lat = k;
        bin = bus.bin_out;
        e   = bus.err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    sys_rst_n  = 1'b0;
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    vec_cnt++;
    if (bus.busy !== 1'b0) begin
      miss_cnt++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    vec_cnt++;
    if (bus.valid !== 1'b0) begin
      miss_cnt++; $display("FAIL reset_valid: got %b want 0", bus.valid);
    end
    vec_cnt++;
    if (bus.bin_out !== 14'h0000) begin
      miss_cnt++; $display("FAIL reset_bin: got %h want 0000", bus.bin_out);
    end
    vec_cnt++;
    if (bus.err !== 1'b0) begin
      miss_cnt++; $display("FAIL reset_err: got %b want 0", bus.err);
    end
    vec_cnt++;
    if (state_dbg !== 2'd0) begin
      miss_cnt++; $display("FAIL reset_state: got %0d want 0", state_dbg);
    end
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_basic();
    logic [BIN_W-1:0] bin;
    logic e;
    int lat, bc;
    do_conv(16'h1234, bin, e, lat, bc);
    vec_cnt++;
    if (lat !== LAT) begin
      miss_cnt++; $display("FAIL basic_latency: got %0d want %0d", lat, LAT);
    end
    vec_cnt++;
    if (bc !== DIGITS + 1) begin
      miss_cnt++; $display("FAIL basic_busy_cycles: got %0d want %0d", bc, DIGITS + 1);
    end
    vec_cnt++;
    if (bin !== 14'h04D2) begin
      miss_cnt++; $display("FAIL basic_bin: got %h want 04d2", bin);
    end
    vec_cnt++;
    if (e !== 1'b0) begin
      miss_cnt++; $display("FAIL basic_err: got %b want 0", e);
    end
    @(negedge sys_clk);
    vec_cnt++;
    if (bus.valid !== 1'b0) begin
      miss_cnt++; $display("FAIL basic_valid_width: got %b want 0", bus.valid);
    end
    vec_cnt++;
    if (bus.bin_out !== 14'h04D2) begin
      miss_cnt++; $display("FAIL basic_bin_hold: got %h want 04d2", bus.bin_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [BIN_W-1:0] bin;
    logic e;
    int lat, bc;
    do_conv(16'h9999, bin, e, lat, bc);
    vec_cnt++;
    if (lat !== LAT || bin !== 14'h270F) begin
      miss_cnt++; $display("FAIL b2b_9999: got lat %0d bin %h want lat %0d bin 270f", lat, bin, LAT);
    end
    // Start lands in the valid cycle and must be accepted.
    do_conv(16'h0000, bin, e, lat, bc);
    vec_cnt++;
    if (lat !== LAT || bin !== 14'h0000) begin
      miss_cnt++; $display("FAIL b2b_0000: got lat %0d bin %h want lat %0d bin 0000", lat, bin, LAT);
    end
    @(negedge sys_clk);
  endtask

  task automatic test_ignore_busy();
    int pulses;
    pulses = 0;
    bus.start  = 1'b1;
    bus.bcd_in = 16'h0042;
    @(posedge sys_clk);
    #1 bus.start = 1'b0;
    @(posedge sys_clk);
    #1;
    @(posedge sys_clk);
    #1 bus.start = 1'b1;
    bus.bcd_in = 16'h0777;
    @(posedge sys_clk);
    #1 bus.start = 1'b0;
    bus.bcd_in = 16'h0000;
    for (int k = 3; k < 15; k++) begin
      @(negedge sys_clk);
      if (k == 3) begin
        vec_cnt++;
        if (bus.bin_out !== 14'h0000) begin
          miss_cnt++; $display("FAIL busy_bin_held: got %h want 0000", bus.bin_out);
        end
      end
      if (bus.valid) begin
        pulses++;
        vec_cnt++;
        if (bus.bin_out !== 14'h002A || k !== LAT) begin
          miss_cnt++; $display("FAIL busy_result: got bin %h at edge %0d want 002a at %0d", bus.bin_out, k, LAT);
        end
      end
    end
    vec_cnt++;
    if (pulses !== 1) begin
      miss_cnt++; $display("FAIL busy_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_reset_abort();
    logic [BIN_W-1:0] bin;
    logic e;
    int lat, bc, pulses;
    bus.start  = 1'b1;
    bus.bcd_in = 16'h5678;
    @(posedge sys_clk);
    #1 bus.start = 1'b0;
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b0;
    @(posedge sys_clk);
    @(negedge sys_clk);
    vec_cnt++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || state_dbg !== 2'd0) begin
      miss_cnt++; $display("FAIL abort_ctrl: got busy %b valid %b state %0d want 0 0 0", bus.busy, bus.valid, state_dbg);
    end
    vec_cnt++;
    if (bus.bin_out !== 14'h0000) begin
      miss_cnt++; $display("FAIL abort_bin: got %h want 0000", bus.bin_out);
    end
    sys_rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge sys_clk);
      if (bus.valid) pulses++;
    end
    vec_cnt++;
    if (pulses !== 0) begin
      miss_cnt++; $display("FAIL abort_no_valid: got %0d pulses want 0", pulses);
    end
    do_conv(16'h0010, bin, e, lat, bc);
    vec_cnt++;
    if (lat !== LAT || bin !== 14'h000A) begin
      miss_cnt++; $display("FAIL abort_restart: got lat %0d bin %h want lat %0d bin 000a", lat, bin, LAT);
    end
    @(negedge sys_clk);
  endtask

  task automatic test_bad_digit();
    logic [BIN_W-1:0] bin;
    logic e;
    int lat, bc;
    logic [BIN_W-1:0] exp_a, exp_b;
    logic exp_e;
`ifdef BCD_TO_BIN_CHECK_EN
    exp_a = 14'h3FFF;
    exp_b = 14'h3FFF;
    exp_e = 1'b1;
`else
    exp_a = 14'h0518;   // 1*1000 + 2*100 + 10*10 + 4 = 1304
    exp_b = 14'h0119;   // 15*1111 = 16665, mod 16384 = 281
    exp_e = 1'b0;
`endif
    do_conv(16'h12A4, bin, e, lat, bc);
    vec_cnt++;
    if (lat !== LAT || bin !== exp_a || e !== exp_e) begin
      miss_cnt++; $display("FAIL bad_12a4: got lat %0d bin %h err %b want lat %0d bin %h err %b", lat, bin, e, LAT, exp_a, exp_e);
    end
    do_conv(16'hFFFF, bin, e, lat, bc);
    vec_cnt++;
    if (lat !== LAT || bin !== exp_b || e !== exp_e) begin
      miss_cnt++; $display("FAIL bad_ffff: got lat %0d bin %h err %b want lat %0d bin %h err %b", lat, bin, e, LAT, exp_b, exp_e);
    end
    // A clean operand afterwards must clear the error state.
    do_conv(16'h0005, bin, e, lat, bc);
    vec_cnt++;
    if (bin !== 14'h0005 || e !== 1'b0) begin
      miss_cnt++; $display("FAIL bad_recover: got bin %h err %b want 0005 0", bin, e);
    end
    @(negedge sys_clk);
  endtask

  task automatic test_hold_start();
    bus.start  = 1'b1;
    bus.bcd_in = 16'h0001;
    for (int k = 0; k < 20; k++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      vec_cnt++;
      if (bus.valid !== ((k % (DIGITS + 2)) == LAT)) begin
        miss_cnt++; $display("FAIL hold_valid_e%0d: got %b want %b", k, bus.valid, ((k % (DIGITS + 2)) == LAT));
      end
      if (bus.valid) begin
        vec_cnt++;
        if (bus.bin_out !== 14'h0001 || bus.err !== 1'b0) begin
          miss_cnt++; $display("FAIL hold_bin_e%0d: got %h err %b want 0001 0", k, bus.bin_out, bus.err);
        end
      end
    end
    bus.start = 1'b0;
    repeat (12) @(negedge sys_clk);
    vec_cnt++;
    if (bus.busy !== 1'b0 || state_dbg !== 2'd0) begin
      miss_cnt++; $display("FAIL hold_drain: got busy %b state %0d want 0 0", bus.busy, state_dbg);
    end
  endtask

  initial begin
    vec_cnt  = 0;
    miss_cnt = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_busy();
    test_reset_abort();
    test_bad_digit();
    test_hold_start();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
